// File: rtl/synch_fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and read-mode encodings.
package synch_fifo_pkg;

  // Default geometry
  localparam int unsigned FIFO_WIDTH_DEF  = 32;
  localparam int unsigned FIFO_DEEPTH_DEF = 16;
  localparam int unsigned FIFO_PTR_DEF    = 4;

  // Read-mode encodings for the FWFT parameter
  localparam int unsigned FWFT_REGISTERED  = 0;  // read data registered one cycle after pop
  localparam int unsigned FWFT_FALLTHROUGH = 1;  // head entry presented combinationally

endpackage : synch_fifo_pkg

// File: rtl/synch_fifo_mem.sv
// Storage for the synchronous FIFO: DEPTH x DATA_W register array,
// one synchronous write port and one asynchronous read port. Not reset.
// Ports:
//   clk      - write clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - read data (combinational from rd_addr)
module synch_fifo_mem
  import synch_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH  = FIFO_DEEPTH_DEF,
  parameter int unsigned ADDR_W = FIFO_PTR_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read port
  assign rd_data = mem[rd_addr];

endmodule : synch_fifo_mem

// File: rtl/synch_fifo_gen2.sv
// Synchronous FIFO with registered or first-word-fall-through read,
// occupancy reporting, programmable almost flags and sticky error flags.
// Ports:
//   fifo_clk, rst                      - clock, async active-high reset
//   fifo_wren, fifo_wrdata             - write request and data
//   fifo_rden                          - read request / pop-acknowledge
//   fifo_flush                         - synchronous discard of contents
//   fifo_err_clr                       - clears overflow/underflow
//   fifo_af_thresh, fifo_ae_thresh     - almost-full / almost-empty thresholds
//   fifo_rddata, fifo_rdvalid          - read data and qualifier
//   fifo_full, fifo_empty              - status
//   fifo_almost_full, fifo_almost_empty- threshold status
//   fifo_data_avail, fifo_room_avail   - occupancy / free entries
//   fifo_overflow, fifo_underflow      - sticky error flags
module synch_fifo_gen2
  import synch_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH  = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEEPTH = FIFO_DEEPTH_DEF,
  parameter int unsigned FIFO_PTR    = FIFO_PTR_DEF,
  parameter int unsigned FWFT        = FWFT_REGISTERED
) (
  input  logic                  fifo_clk,
  input  logic                  rst,
  input  logic                  fifo_wren,
  input  logic [FIFO_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_rden,
  input  logic                  fifo_flush,
  input  logic                  fifo_err_clr,
  input  logic [FIFO_PTR:0]     fifo_af_thresh,
  input  logic [FIFO_PTR:0]     fifo_ae_thresh,
  output logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rdvalid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [FIFO_PTR:0]     fifo_data_avail,
  output logic [FIFO_PTR:0]     fifo_room_avail,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int unsigned       CNT_W     = FIFO_PTR + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEEPTH);

  logic [FIFO_PTR-1:0]   wr_ptr;
  logic [FIFO_PTR-1:0]   rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [FIFO_WIDTH-1:0] head_data;
  logic [FIFO_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  ovf_set;
  logic                  unf_set;

  // Status from the registered count only
  assign fifo_full         = (count == DEPTH_CNT);
  assign fifo_empty        = (count == '0);
  assign fifo_data_avail   = count;
  assign fifo_room_avail   = DEPTH_CNT - count;
  assign fifo_almost_full  = (count >= fifo_af_thresh);
  assign fifo_almost_empty = (count <= fifo_ae_thresh);

  // Accept/reject decisions; flush suppresses both transfers and error detection
  always_comb begin
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (!fifo_flush) begin
      wr_accept = fifo_wren && !fifo_full;
      rd_accept = fifo_rden && !fifo_empty;
      ovf_set   = fifo_wren && fifo_full;
      unf_set   = fifo_rden && fifo_empty;
    end
  end

  // Pointers and occupancy; pointer wrap relies on power-of-two depth
  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + FIFO_PTR'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + FIFO_PTR'(1);
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read path: data captured on pop, valid pulses for one cycle
  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= head_data;
      end
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~fifo_err_clr);
      unf_q <= unf_set | (unf_q & ~fifo_err_clr);
    end
  end

  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = unf_q;

  // Fall-through mode presents the head entry directly
  assign fifo_rddata  = (FWFT == FWFT_FALLTHROUGH) ? head_data   : rd_data_q;
  assign fifo_rdvalid = (FWFT == FWFT_FALLTHROUGH) ? !fifo_empty : rd_valid_q;

  synch_fifo_mem #(
    .DATA_W (FIFO_WIDTH),
    .DEPTH  (FIFO_DEEPTH),
    .ADDR_W (FIFO_PTR)
  ) u_mem (
    .clk     (fifo_clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (fifo_wrdata),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

endmodule : synch_fifo_gen2

// File: tb/tb_synch_fifo_gen2.sv
// Bench for synch_fifo_gen2: one registered-read and one fall-through instance
// share all inputs and are compared against a queue-based reference model.
module tb_synch_fifo_gen2;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR   = 4;

  logic          fifo_clk = 1'b0;
  logic          rst;
  logic          fifo_wren;
  logic [W-1:0]  fifo_wrdata;
  logic          fifo_rden;
  logic          fifo_flush;
  logic          fifo_err_clr;
  logic [PTR:0]  fifo_af_thresh;
  logic [PTR:0]  fifo_ae_thresh;

  logic [W-1:0]  rddata0, rddata1;
  logic          rdvalid0, rdvalid1;
  logic          full0, full1, empty0, empty1;
  logic          afull0, afull1, aempty0, aempty1;
  logic [PTR:0]  avail0, avail1, room0, room1;
  logic          ovf0, ovf1, unf0, unf1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0]  q[$];
  logic [W-1:0]  m_rddata0;
  logic          m_rdvalid0;
  logic          m_ovf;
  logic          m_unf;

  always #5 fifo_clk = ~fifo_clk;

  synch_fifo_gen2 #(.FIFO_WIDTH(W), .FIFO_DEEPTH(DEPTH), .FIFO_PTR(PTR), .FWFT(0)) dut_reg (
    .fifo_clk(fifo_clk), .rst(rst), .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
    .fifo_rden(fifo_rden), .fifo_flush(fifo_flush), .fifo_err_clr(fifo_err_clr),
    .fifo_af_thresh(fifo_af_thresh), .fifo_ae_thresh(fifo_ae_thresh),
    .fifo_rddata(rddata0), .fifo_rdvalid(rdvalid0), .fifo_full(full0), .fifo_empty(empty0),
    .fifo_almost_full(afull0), .fifo_almost_empty(aempty0),
    .fifo_data_avail(avail0), .fifo_room_avail(room0),
    .fifo_overflow(ovf0), .fifo_underflow(unf0)
  );

  synch_fifo_gen2 #(.FIFO_WIDTH(W), .FIFO_DEEPTH(DEPTH), .FIFO_PTR(PTR), .FWFT(1)) dut_fwft (
    .fifo_clk(fifo_clk), .rst(rst), .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
    .fifo_rden(fifo_rden), .fifo_flush(fifo_flush), .fifo_err_clr(fifo_err_clr),
    .fifo_af_thresh(fifo_af_thresh), .fifo_ae_thresh(fifo_ae_thresh),
    .fifo_rddata(rddata1), .fifo_rdvalid(rdvalid1), .fifo_full(full1), .fifo_empty(empty1),
    .fifo_almost_full(afull1), .fifo_almost_empty(aempty1),
    .fifo_data_avail(avail1), .fifo_room_avail(room1),
    .fifo_overflow(ovf1), .fifo_underflow(unf1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output against the model
  task automatic check_all();
    int unsigned n;
    n = q.size();
    chk("data_avail",   64'(avail0),  64'(n));
    chk("room_avail",   64'(room0),   64'(DEPTH - n));
    chk("full",         64'(full0),   64'(n == DEPTH));
    chk("empty",        64'(empty0),  64'(n == 0));
    chk("almost_full",  64'(afull0),  64'(n >= 32'(fifo_af_thresh)));
    chk("almost_empty", 64'(aempty0), 64'(n <= 32'(fifo_ae_thresh)));
    chk("overflow",     64'(ovf0),    64'(m_ovf));
    chk("underflow",    64'(unf0),    64'(m_unf));
    chk("rdvalid",      64'(rdvalid0), 64'(m_rdvalid0));
    chk("rddata",       64'(rddata0), 64'(m_rddata0));
    chk("fwft_avail",   64'(avail1),  64'(n));
    chk("fwft_ovf",     64'(ovf1),    64'(m_ovf));
    chk("fwft_rdvalid", 64'(rdvalid1), 64'(n != 0));
    if (n != 0) chk("fwft_rddata", 64'(rddata1), 64'(q[0]));
  endtask

  // One clock of stimulus: predict from the rules, clock, then compare
  task automatic step(input logic wr, input logic [W-1:0] d, input logic rd,
                      input logic fl, input logic ec);
    logic full_m, empty_m, ovs, uns;
    fifo_wren    = wr;
    fifo_wrdata  = d;
    fifo_rden    = rd;
    fifo_flush   = fl;
    fifo_err_clr = ec;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    ovs = wr && full_m && !fl;
    uns = rd && empty_m && !fl;
    if (fl) begin
      q.delete();
      m_rdvalid0 = 1'b0;
    end else begin
      m_rdvalid0 = rd && !empty_m;
      if (rd && !empty_m) m_rddata0 = q.pop_front();
      if (wr && !full_m) q.push_back(d);
    end
    m_ovf = ovs | (m_ovf & ~ec);
    m_unf = uns | (m_unf & ~ec);
    @(posedge fifo_clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned r;
    bit flushed;
    rst = 1'b1;
    fifo_wren = 1'b0; fifo_wrdata = '0; fifo_rden = 1'b0;
    fifo_flush = 1'b0; fifo_err_clr = 1'b0;
    fifo_af_thresh = 5'd12; fifo_ae_thresh = 5'd3;
    q.delete(); m_rddata0 = '0; m_rdvalid0 = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset state before any clock edge
    #2;
    check_all();
    chk("reset_room", 64'(room0), 64'(DEPTH));
    @(posedge fifo_clk); #1;
    rst = 1'b0;
    idle();

    // Five writes then three reads in registered mode
    for (int i = 0; i < 5; i++) step(1'b1, W'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    chk("avail_after_5", 64'(avail0), 64'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("rd_word", 64'(rddata0), 64'(32'h100 + i));
    end
    chk("avail_after_3rd", 64'(avail0), 64'd2);
    idle();
    drain();

    // Underflow on empty, then simultaneous write+read on empty
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("underflow_set", 64'(unf0), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, W'(32'hBEEF), 1'b1, 1'b0, 1'b0);
    chk("wr_rd_empty_cnt", 64'(avail0), 64'd1);
    drain();

    // Fill to full, overflow, full with both requests, clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(32'h200 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, W'(32'hDEAD), 1'b0, 1'b0, 1'b0);
    chk("ovf_full", 64'(full0), 64'd1);
    chk("ovf_room", 64'(room0), 64'd0);
    chk("ovf_flag", 64'(ovf0), 64'd1);
    step(1'b1, W'(32'hCAFE), 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 64'(ovf0), 64'd0);
    drain();
    idle();

    // Fall-through: single write to empty becomes visible next cycle
    step(1'b1, W'(32'hA5A5A5A5), 1'b0, 1'b0, 1'b0);
    chk("fwft_a5", 64'(rddata1), 64'h0000_0000_A5A5_A5A5);
    chk("fwft_valid", 64'(rdvalid1), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fwft_popped", 64'(rdvalid1), 64'd0);

    // Random interleaving with a flush when occupancy reaches 7
    flushed = 1'b0;
    for (int i = 0; i < 200 && !(flushed && i >= 40); i++) begin
      if (!flushed && q.size() == 7) begin
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("flush_empty", 64'(empty0), 64'd1);
        flushed = 1'b1;
      end else begin
        step(1'($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom_range(0, 9) < 4),
             1'b0, 1'b0);
      end
    end
    chk("flush_reached", 64'(flushed), 64'd1);
    drain();

    // Long random run with random thresholds, clears and rare flushes
    for (int i = 0; i < 400; i++) begin
      fifo_af_thresh = 5'($urandom_range(0, 20));
      fifo_ae_thresh = 5'($urandom_range(0, 20));
      r = $urandom_range(0, 99);
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           1'(r < 3), 1'(r > 90));
    end

    // Asynchronous reset in the middle of activity
    fifo_af_thresh = 5'd12; fifo_ae_thresh = 5'd3;
    for (int i = 0; i < 20; i++) step(1'b1, W'(32'h300 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    fifo_wren = 1'b0; fifo_rden = 1'b0; fifo_err_clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    q.delete(); m_rddata0 = '0; m_rdvalid0 = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    check_all();
    @(posedge fifo_clk); #1;
    rst = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) step(1'b1, W'(32'h400 + i), 1'b0, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_synch_fifo_gen2
